// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore control FSM sequencing the multicycle MIPS datapath.
module mips_multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic [2:0]         alu_control,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               iord,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic [1:0]         pc_src,
    output logic               pc_en,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);
    typedef enum logic [STATE_W-1:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX
    } state_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                           F_OR = 6'b100101, F_SLT = 6'b101010;

    state_t state, nextState, decodeNext;
    logic rtypeOk, memWr, irWr, regWr, pcEn, done, illegal;
    logic [2:0] rtypeAlu;

    assign rtypeOk = op == OP_R && funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
    assign rtypeAlu = funct == F_SUB ? 3'b110 :
                      funct == F_AND ? 3'b000 :
                      funct == F_OR  ? 3'b001 :
                      funct == F_SLT ? 3'b111 : 3'b010;
    assign decodeNext = (op == OP_LW || op == OP_SW) ? MEMADR :
                        rtypeOk        ? RTYPEEX :
                        op == OP_BEQ   ? BEQEX :
                        op == OP_ADDI  ? ADDIEX :
                        op == OP_J     ? JEX : FETCH;

    always_ff @(posedge clk) begin
        if (reset)
            state <= FETCH;
        else
            state <= nextState;
    end

    always_comb begin
        nextState   = FETCH;
        alu_control = 3'b010;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        pc_src      = 2'b00;
        memWr       = 1'b0;
        irWr        = 1'b0;
        regWr       = 1'b0;
        pcEn        = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (state)
            FETCH: begin
                alu_src_b = 2'b01;
                irWr      = 1'b1;
                pcEn      = 1'b1;
                nextState = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                nextState = decodeNext;
                illegal   = decodeNext == FETCH;
                done      = decodeNext == FETCH;
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nextState = op == OP_LW ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord      = 1'b1;
                nextState = MEMWB;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                regWr      = 1'b1;
                done       = 1'b1;
            end
            MEMWR: begin
                iord  = 1'b1;
                memWr = 1'b1;
                done  = 1'b1;
            end
            RTYPEEX: begin
                alu_src_a   = 1'b1;
                alu_control = rtypeAlu;
                nextState   = RTYPEWB;
            end
            RTYPEWB: begin
                reg_dst = 1'b1;
                regWr   = 1'b1;
                done    = 1'b1;
            end
            BEQEX: begin
                alu_src_a   = 1'b1;
                alu_control = 3'b110;
                pc_src      = 2'b01;
                pcEn        = zero;
                done        = 1'b1;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nextState = ADDIWB;
            end
            ADDIWB: begin
                regWr = 1'b1;
                done  = 1'b1;
            end
            JEX: begin
                pc_src = 2'b10;
                pcEn   = 1'b1;
                done   = 1'b1;
            end
            default: nextState = FETCH;
        endcase
    end

    // Reset aborts any in-flight instruction: no architectural write may escape.
    assign mem_write  = memWr & ~reset;
    assign ir_write   = irWr & ~reset;
    assign reg_write  = regWr & ~reset;
    assign pc_en      = pcEn & ~reset;
    assign instr_done = done & ~reset;
    assign illegal_op = illegal & ~reset;
    assign state_dbg  = state;
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style control FSM that sequences the shared 32-bit ALU, register file, instruction/data memory port and PC of the multicycle MIPS core.
- Every cycle it drives the ALU operation select (010 add, 110 sub, 000 and, 001 or, 111 slt), the ALU operand muxes and the datapath write enables.
- It decodes op/funct from the instruction register and steps through per-instruction states.
- Supported instructions: lw, sw, R-type add/sub/and/or/slt, beq, addi, j.

Parameters:
STATE_W, 4, width of the state register and of the state_dbg port.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
op  in  6  instr[31:26] from the instruction register
funct  in  6  instr[5:0] from the instruction register
zero  in  1  ALU zero flag, same cycle
alu_control  out  3  ALU operation select
alu_src_a  out  1  0 = PC, 1 = register A
alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_write  out  1  data memory write enable
ir_write  out  1  instruction register load
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = memory data
reg_write  out  1  register file write enable
pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
pc_en  out  1  PC load enable
instr_done  out  1  pulses in the final cycle of each instruction
illegal_op  out  1  pulses in DECODE for an unsupported op/funct
state_dbg  out  STATE_W  current state encoding

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high; the state register loads FETCH on the next clk edge while reset=1.
- Outputs during reset: while reset=1, mem_write, ir_write, reg_write, pc_en, instr_done and illegal_op are forced to 0, regardless of state. This holds for reset asserted mid-instruction too: the instruction is aborted and no write occurs.
- After reset release: first cycle is FETCH.
- Output decode: all outputs are combinational decodes of the state (plus zero, op, funct where noted below). Any output not listed for a state is 0; alu_control defaults to 010.
- State encoding (state_dbg): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
- States 12-15 are unreachable; if entered, next state is FETCH and all enables are 0.
- Per-state outputs and transitions:
  - FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_control=010, pc_src=00, ir_write=1, pc_en=1. Next: DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_control=010 (branch target into ALUOut). Next, by op:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 with funct in {100000, 100010, 100100, 100101, 101010} -> RTYPEEX
    - 000100 (beq) -> BEQEX
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JEX
    - anything else -> FETCH, with illegal_op=1 and instr_done=1 (instruction skipped; PC already advanced)
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_control=010. Next: MEMRD if op=lw, else MEMWR.
  - MEMRD: iord=1. Next: MEMWB.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1. Next: FETCH.
  - MEMWR: iord=1, mem_write=1, instr_done=1. Next: FETCH.
  - RTYPEEX: alu_src_a=1, alu_src_b=00. alu_control from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111. Next: RTYPEWB.
  - RTYPEWB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1. Next: FETCH.
  - BEQEX: alu_src_a=1, alu_src_b=00, alu_control=110, pc_src=01, pc_en=zero, instr_done=1. Next: FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_control=010. Next: ADDIWB.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1. Next: FETCH.
  - JEX: pc_src=10, pc_en=1, instr_done=1. Next: FETCH.
- Latency in cycles, FETCH included: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Input sampling: op and funct are sampled only in DECODE, MEMADR and RTYPEEX. They are stable because ir_write=1 only in FETCH.
- Pulse widths: instr_done and illegal_op are each exactly one cycle wide.
- pc_en: pc_en=1 only in FETCH, JEX, and BEQEX with zero=1.

Test Plan:
- Reset held 3 cycles from an arbitrary state, then released -> no write enables while reset=1; state_dbg=0 on the first post-reset cycle; ir_write=1, pc_en=1, alu_control=010, alu_src_b=01.
- lw (op=100011) -> state_dbg sequence 0,1,2,3,4; reg_write=1 with mem_to_reg=1 only in cycle 5; instr_done high in cycle 5 only. sw -> sequence 0,1,2,5 with mem_write=1 in cycle 4.
- R-type funct 100010 then funct 101010 -> alu_control=110 then 111 in RTYPEEX; reg_dst=1 and reg_write=1 in RTYPEWB.
- beq (op=000100) with zero=1 -> pc_en=1, pc_src=01 in BEQEX; repeat with zero=0 -> pc_en=0; both return to FETCH after 3 cycles.
- op=111111, then op=000000 with funct=000111 -> illegal_op=1 and instr_done=1 in DECODE; next state FETCH; reg_write and mem_write never asserted.
- reset asserted during MEMWR and during RTYPEWB -> mem_write=0 and reg_write=0 in that cycle; FETCH on the next cycle.
